// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode trap sequencer: CSR
// addresses, mstatus/mie bit positions, mcause codes and the sequencer states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [31:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'h0000_000B;

    typedef enum logic [3:0] {
        IDLE,
        RD_STATUS,
        RD_MIE,
        WR_MEPC,
        WR_MCAUSE,
        WR_STATUS,
        WR_STATUS_MRET,
        RD_MEPC,
        REDIRECT
    } state_e;

    // mstatus image written on trap entry: stash MIE into MPIE, disable, enter M-mode.
    function automatic logic [31:0] trap_entry_status(input logic [31:0] status);
        logic [31:0] s;
        s = status;
        s[MSTATUS_MPIE] = status[MSTATUS_MIE];
        s[MSTATUS_MIE]  = 1'b0;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return s;
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] status);
        logic [31:0] s;
        s = status;
        s[MSTATUS_MIE]  = status[MSTATUS_MPIE];
        s[MSTATUS_MPIE] = 1'b1;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return s;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: saves/restores state through the CSR port on
// ecall, enabled interrupts and mret, then redirects fetch.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC    = 32'h0000_0100,
    parameter bit          VECTORED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc_i,
    input  logic        ecall,
    input  logic        is_mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_rd,
    output logic        csr_wr,
    input  logic [31:0] csr_rdata,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_mepc;
    logic        r_ecall;
    logic        r_ext;
    logic        r_timer;
    logic        trap_pending_q;

    logic        w_trigger;
    logic        w_cause_valid;
    logic [31:0] w_cause;
    logic [31:0] w_trap_pc;

    // Gated with rst so every output reads 0 while reset is held.
    assign w_trigger = rst & inst_valid & (is_mret | ecall | ext_irq | timer_irq);

    // Cause selection happens while mie is on the read bus (RD_MIE).
    always_comb begin
        w_cause_valid = 1'b1;
        w_cause       = '0;
        if (r_ext && r_status[MSTATUS_MIE] && csr_rdata[MIE_MEIE])
            w_cause = CAUSE_M_EXT_IRQ;
        else if (r_timer && r_status[MSTATUS_MIE] && csr_rdata[MIE_MTIE])
            w_cause = CAUSE_M_TIMER_IRQ;
        else if (r_ecall)
            w_cause = CAUSE_ECALL_M;
        else
            w_cause_valid = 1'b0;
    end

    assign w_trap_pc = (VECTORED && r_cause[31]) ? MTVEC + {r_cause[29:0], 2'b00} : MTVEC;

    // NOTE: every output and w_next gets a default up front so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next      = r_state;
        csr_addr    = '0;
        csr_wdata   = '0;
        csr_rd      = 1'b0;
        csr_wr      = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                stall = w_trigger;
                if (w_trigger) w_next = RD_STATUS;
            end
            RD_STATUS: begin
                stall    = 1'b1;
                csr_rd   = 1'b1;
                csr_addr = CSR_MSTATUS;
                w_next   = trap_pending_q ? RD_MIE : WR_STATUS_MRET;
            end
            RD_MIE: begin
                stall    = 1'b1;
                csr_rd   = 1'b1;
                csr_addr = CSR_MIE;
                w_next   = w_cause_valid ? WR_MEPC : IDLE;
            end
            WR_MEPC: begin
                stall     = 1'b1;
                csr_wr    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = r_pc & 32'hFFFF_FFFC;
                w_next    = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                stall     = 1'b1;
                csr_wr    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = r_cause;
                w_next    = WR_STATUS;
            end
            WR_STATUS: begin
                stall     = 1'b1;
                csr_wr    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = trap_entry_status(r_status);
                w_next    = REDIRECT;
            end
            WR_STATUS_MRET: begin
                stall     = 1'b1;
                csr_wr    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = mret_status(r_status);
                w_next    = RD_MEPC;
            end
            RD_MEPC: begin
                stall    = 1'b1;
                csr_rd   = 1'b1;
                csr_addr = CSR_MEPC;
                w_next   = REDIRECT;
            end
            REDIRECT: begin
                redirect    = 1'b1;
                flush       = 1'b1;
                redirect_pc = trap_pending_q ? w_trap_pc : (r_mepc & 32'hFFFF_FFFC);
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_pc           <= '0;
            r_status       <= '0;
            r_cause        <= '0;
            r_mepc         <= '0;
            r_ecall        <= 1'b0;
            r_ext          <= 1'b0;
            r_timer        <= 1'b0;
            trap_pending_q <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_trigger) begin
                    r_pc           <= pc_i;
                    r_ecall        <= ecall;
                    r_ext          <= ext_irq;
                    r_timer        <= timer_irq;
                    trap_pending_q <= ~is_mret;
                end
                RD_STATUS: r_status <= csr_rdata;
                RD_MIE:    r_cause  <= w_cause;
                RD_MEPC:   r_mepc   <= csr_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl (VECTORED=1) against a small behavioural
// CSR file; expected per-cycle outputs are hand-computed tables.
module tb_csr_trap_ctrl;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic        busy;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rpc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ecall = 1'b0;
    logic        is_mret = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rd;
    logic        csr_wr;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Behavioural CSR file, preloaded through ld_* at a clock edge.
    logic [31:0] m_mstatus = '0, m_mie = '0, m_mepc = '0, m_mcause = '0;
    int          wr_count = 0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_mstatus = '0, ld_mie = '0, ld_mepc = '0, ld_mcause = '0;

    csr_trap_ctrl #(.MTVEC(32'h0000_0100), .VECTORED(1'b1)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_i(pc_i),
        .ecall(ecall), .is_mret(is_mret), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rd(csr_rd), .csr_wr(csr_wr),
        .csr_rdata(csr_rdata), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_rdata = '0;
        if (csr_rd) begin
            case (csr_addr)
                12'h300: csr_rdata = m_mstatus;
                12'h304: csr_rdata = m_mie;
                12'h341: csr_rdata = m_mepc;
                12'h342: csr_rdata = m_mcause;
                default: csr_rdata = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (ld_en) begin
            m_mstatus <= ld_mstatus;
            m_mie     <= ld_mie;
            m_mepc    <= ld_mepc;
            m_mcause  <= ld_mcause;
            wr_count  <= 0;
        end else if (csr_wr) begin
            wr_count <= wr_count + 1;
            case (csr_addr)
                12'h300: m_mstatus <= csr_wdata;
                12'h304: m_mie     <= csr_wdata;
                12'h341: m_mepc    <= csr_wdata;
                12'h342: m_mcause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    function automatic out_t obs();
        return '{stall, flush, redirect, busy, csr_rd, csr_wr, csr_addr, csr_wdata, redirect_pc};
    endfunction

    function automatic out_t mk(input logic s, input logic f, input logic r, input logic b,
                                input logic rd, input logic wr, input logic [11:0] a,
                                input logic [31:0] wd, input logic [31:0] rp);
        return '{s, f, r, b, rd, wr, a, wd, rp};
    endfunction

    task automatic preload(input logic [31:0] st, input logic [31:0] ie,
                           input logic [31:0] epc, input logic [31:0] cause);
        @(negedge clk);
        ld_mstatus = st; ld_mie = ie; ld_mepc = epc; ld_mcause = cause;
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_inputs();
        inst_valid = 1'b0; ecall = 1'b0; is_mret = 1'b0;
        ext_irq = 1'b0; timer_irq = 1'b0; pc_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            $display("FAIL reset_hold outputs got %h want 0", obs()); errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            $display("FAIL reset_release outputs got %h want 0", obs()); errors++;
        end
    endtask

    task automatic test_ecall();
        out_t exp [0:7];
        preload(32'h8, 32'h0, 32'h0, 32'h0);
        exp[0] = mk(1, 0, 0, 0, 0, 0, 12'h000, 32'h0, 32'h0);
        exp[1] = mk(1, 0, 0, 1, 1, 0, 12'h300, 32'h0, 32'h0);
        exp[2] = mk(1, 0, 0, 1, 1, 0, 12'h304, 32'h0, 32'h0);
        exp[3] = mk(1, 0, 0, 1, 0, 1, 12'h341, 32'h40, 32'h0);
        exp[4] = mk(1, 0, 0, 1, 0, 1, 12'h342, 32'hB, 32'h0);
        exp[5] = mk(1, 0, 0, 1, 0, 1, 12'h300, 32'h1880, 32'h0);
        exp[6] = mk(0, 1, 1, 1, 0, 0, 12'h000, 32'h0, 32'h100);
        exp[7] = '0;
        @(negedge clk);
        inst_valid = 1'b1; ecall = 1'b1; pc_i = 32'h0000_0040;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                $display("FAIL ecall_T%0d got %h want %h", i, obs(), exp[i]); errors++;
            end
            if (i == 0) begin
                @(posedge clk); #1;
                clear_inputs();
            end
        end
        checks++;
        if ({m_mepc, m_mcause, m_mstatus} !== {32'h40, 32'hB, 32'h1880} || wr_count != 3) begin
            $display("FAIL ecall_csrs got mepc=%h mcause=%h mstatus=%h writes=%0d want 40 b 1880 3",
                     m_mepc, m_mcause, m_mstatus, wr_count); errors++;
        end
    endtask

    task automatic test_ext_vectored();
        out_t exp [1:7];
        preload(32'h8, 32'h880, 32'h0, 32'h0);
        exp[1] = mk(1, 0, 0, 1, 1, 0, 12'h300, 32'h0, 32'h0);
        exp[2] = mk(1, 0, 0, 1, 1, 0, 12'h304, 32'h0, 32'h0);
        exp[3] = mk(1, 0, 0, 1, 0, 1, 12'h341, 32'h1234_5678, 32'h0);
        exp[4] = mk(1, 0, 0, 1, 0, 1, 12'h342, 32'h8000_000B, 32'h0);
        exp[5] = mk(1, 0, 0, 1, 0, 1, 12'h300, 32'h1880, 32'h0);
        exp[6] = mk(0, 1, 1, 1, 0, 0, 12'h000, 32'h0, 32'h12C);
        exp[7] = '0;
        @(negedge clk);
        inst_valid = 1'b1; ext_irq = 1'b1; timer_irq = 1'b1; pc_i = 32'h1234_567B;
        @(posedge clk); #1;
        // irq levels drop and inst_valid stays low: the latched request must still complete.
        clear_inputs();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                $display("FAIL ext_irq_T%0d got %h want %h", i, obs(), exp[i]); errors++;
            end
        end
        checks++;
        if (m_mcause !== 32'h8000_000B || m_mepc !== 32'h1234_5678) begin
            $display("FAIL ext_irq_csrs got mcause=%h mepc=%h want 8000000b 12345678",
                     m_mcause, m_mepc); errors++;
        end
    endtask

    task automatic test_timer_masked();
        out_t exp [1:4];
        preload(32'h0, 32'h80, 32'h5555_0000, 32'hDEAD);
        exp[1] = mk(1, 0, 0, 1, 1, 0, 12'h300, 32'h0, 32'h0);
        exp[2] = mk(1, 0, 0, 1, 1, 0, 12'h304, 32'h0, 32'h0);
        exp[3] = '0;
        exp[4] = '0;
        @(negedge clk);
        inst_valid = 1'b1; timer_irq = 1'b1; pc_i = 32'h80;
        @(posedge clk); #1;
        clear_inputs();
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                $display("FAIL timer_masked_T%0d got %h want %h", i, obs(), exp[i]); errors++;
            end
        end
        checks++;
        if (wr_count != 0 || m_mcause !== 32'hDEAD) begin
            $display("FAIL timer_masked_writes got writes=%0d mcause=%h want 0 dead",
                     wr_count, m_mcause); errors++;
        end
    endtask

    task automatic test_mret();
        out_t exp [0:5];
        // Interrupt enabled and pending alongside mret: mret wins.
        preload(32'h1880, 32'h880, 32'h46, 32'h0);
        exp[0] = mk(1, 0, 0, 0, 0, 0, 12'h000, 32'h0, 32'h0);
        exp[1] = mk(1, 0, 0, 1, 1, 0, 12'h300, 32'h0, 32'h0);
        exp[2] = mk(1, 0, 0, 1, 0, 1, 12'h300, 32'h1888, 32'h0);
        exp[3] = mk(1, 0, 0, 1, 1, 0, 12'h341, 32'h0, 32'h0);
        exp[4] = mk(0, 1, 1, 1, 0, 0, 12'h000, 32'h0, 32'h44);
        exp[5] = '0;
        @(negedge clk);
        inst_valid = 1'b1; is_mret = 1'b1; ecall = 1'b1; ext_irq = 1'b1; pc_i = 32'h200;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                $display("FAIL mret_T%0d got %h want %h", i, obs(), exp[i]); errors++;
            end
            if (i == 0) begin
                @(posedge clk); #1;
                clear_inputs();
            end
        end
        checks++;
        if (m_mstatus !== 32'h1888 || m_mepc !== 32'h46 || wr_count != 1) begin
            $display("FAIL mret_csrs got mstatus=%h mepc=%h writes=%0d want 1888 46 1",
                     m_mstatus, m_mepc, wr_count); errors++;
        end
    endtask

    task automatic test_reset_mid_sequence();
        out_t exp_mcause;
        preload(32'h8, 32'h0, 32'h0, 32'h0);
        exp_mcause = mk(1, 0, 0, 1, 0, 1, 12'h342, 32'hB, 32'h0);
        @(negedge clk);
        inst_valid = 1'b1; ecall = 1'b1; pc_i = 32'h0000_0300;
        @(posedge clk); #1;
        clear_inputs();
        repeat (4) @(negedge clk);
        checks++;
        if (obs() !== exp_mcause) begin
            $display("FAIL midreset_pre got %h want %h", obs(), exp_mcause); errors++;
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            $display("FAIL midreset_async got %h want 0", obs()); errors++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            $display("FAIL midreset_release got %h want 0", obs()); errors++;
        end
        checks++;
        if (m_mepc !== 32'h300) begin
            $display("FAIL midreset_partial_mepc got %h want 300", m_mepc); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_ext_vectored();
        test_timer_masked();
        test_mret();
        test_reset_mid_sequence();
        test_ecall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
